spi_sub: RTL and testbench

- MSB-first SPI subordinate (responder) for the team's SPI main frame format.
- Frame layout: 1 R/W bit (1 = write, 0 = read), then ADDR_WIDTH address bits, then DATA_WIDTH data bits.
- Everything runs in the local clk domain. sclk, cs and mosi are oversampled and synchronised.
- Decoded frames become single-cycle register-file accesses on a simple backend port. Typical use: peripheral register bank on an FPGA, or test-bench partner for the main.

---
 rtl/spi_sub.sv | 212 +++++++++++++++++++++
 tb/tb_spi_sub.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_sub.sv
// SPI mode-3 subordinate: oversamples sclk/cs/mosi in the clk domain and turns each
// R/W + address + data frame into a single-cycle register-file access.
module spi_sub #(
  parameter int ADDR_WIDTH  = 6,
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic                  reg_wr_en,
  output logic [DATA_WIDTH-1:0] reg_wr_data,
  output logic                  reg_rd_en,
  input  logic [DATA_WIDTH-1:0] reg_rd_data,
  output logic                  busy,
  output logic                  frame_err
);

  localparam int MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RW   = 3'd1;
  localparam logic [2:0] S_ADDR = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   cs_prev_q, cs_prev_d;

  logic [2:0]            state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  is_write_q, is_write_d;
  logic [ADDR_WIDTH-1:0] addr_sh_q, addr_sh_d;
  logic [DATA_WIDTH-1:0] data_sh_q, data_sh_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic                  miso_q, miso_d;
  logic [ADDR_WIDTH-1:0] reg_addr_q, reg_addr_d;
  logic                  reg_wr_en_q, reg_wr_en_d;
  logic [DATA_WIDTH-1:0] reg_wr_data_q, reg_wr_data_d;
  logic                  reg_rd_en_q, reg_rd_en_d;
  logic                  rd_load_q, rd_load_d;
  logic                  frame_err_q, frame_err_d;
  logic                  ovl_q, ovl_d;

  logic sclk_s, cs_s, mosi_s;
  logic rise, fall, cs_rise, cs_fall, final_rise;

  assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s    = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync_q[SYNC_STAGES-1];
  assign rise    = sclk_s & ~sclk_prev_q;
  assign fall    = ~sclk_s & sclk_prev_q;
  assign cs_rise = cs_s & ~cs_prev_q;
  assign cs_fall = ~cs_s & cs_prev_q;
  assign final_rise = rise && (bit_cnt_q == '0);

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    sclk_prev_d = sclk_s;
    cs_prev_d   = cs_s;
  end

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    is_write_d    = is_write_q;
    addr_sh_d     = addr_sh_q;
    data_sh_d     = data_sh_q;
    tx_d          = tx_q;
    miso_d        = miso_q;
    reg_addr_d    = reg_addr_q;
    reg_wr_en_d   = 1'b0;
    reg_wr_data_d = reg_wr_data_q;
    reg_rd_en_d   = 1'b0;
    rd_load_d     = reg_rd_en_q;
    frame_err_d   = 1'b0;
    ovl_d         = ovl_q;

    // Backend read data is valid exactly one clk after the request.
    if (rd_load_q) tx_d = reg_rd_data;

    case (state_q)
      S_IDLE: begin
        miso_d = 1'b0;
        ovl_d  = 1'b0;
        if (cs_fall) state_d = S_RW;
      end
      S_RW: begin
        if (cs_rise) begin
          state_d     = S_IDLE;
          frame_err_d = 1'b1;
        end else if (rise) begin
          is_write_d = mosi_s;
          bit_cnt_d  = CNT_W'(ADDR_WIDTH - 1);
          state_d    = S_ADDR;
        end
      end
      S_ADDR: begin
        if (cs_rise) begin
          state_d     = S_IDLE;
          frame_err_d = 1'b1;
        end else if (rise) begin
          addr_sh_d = {addr_sh_q[ADDR_WIDTH-2:0], mosi_s};
          if (bit_cnt_q == '0) begin
            reg_addr_d  = addr_sh_d;
            reg_rd_en_d = ~is_write_q;
            bit_cnt_d   = CNT_W'(DATA_WIDTH - 1);
            state_d     = S_DATA;
          end else begin
            bit_cnt_d = bit_cnt_q - 1'b1;
          end
        end
      end
      S_DATA: begin
        // A cs rise coinciding with the last data rise still completes the frame.
        if (cs_rise && !final_rise) begin
          state_d     = S_IDLE;
          frame_err_d = 1'b1;
          miso_d      = 1'b0;
        end else if (rise) begin
          data_sh_d = {data_sh_q[DATA_WIDTH-2:0], mosi_s};
          if (bit_cnt_q == '0) begin
            reg_wr_en_d = is_write_q;
            if (is_write_q) reg_wr_data_d = data_sh_d;
            miso_d  = 1'b0;
            state_d = S_DONE;
          end else begin
            bit_cnt_d = bit_cnt_q - 1'b1;
          end
        end else if (fall && !is_write_q) begin
          miso_d = tx_q[DATA_WIDTH-1];
          tx_d   = {tx_q[DATA_WIDTH-2:0], 1'b0};
        end
      end
      S_DONE: begin
        miso_d = 1'b0;
        if (cs_s) begin
          state_d = S_IDLE;
        end else if (rise && !ovl_q) begin
          frame_err_d = 1'b1;
          ovl_d       = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q   <= '1;
      cs_sync_q     <= '1;
      mosi_sync_q   <= '0;
      sclk_prev_q   <= 1'b1;
      cs_prev_q     <= 1'b1;
      state_q       <= S_IDLE;
      bit_cnt_q     <= '0;
      is_write_q    <= 1'b0;
      addr_sh_q     <= '0;
      data_sh_q     <= '0;
      tx_q          <= '0;
      miso_q        <= 1'b0;
      reg_addr_q    <= '0;
      reg_wr_en_q   <= 1'b0;
      reg_wr_data_q <= '0;
      reg_rd_en_q   <= 1'b0;
      rd_load_q     <= 1'b0;
      frame_err_q   <= 1'b0;
      ovl_q         <= 1'b0;
    end else begin
      sclk_sync_q   <= sclk_sync_d;
      cs_sync_q     <= cs_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      sclk_prev_q   <= sclk_prev_d;
      cs_prev_q     <= cs_prev_d;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      is_write_q    <= is_write_d;
      addr_sh_q     <= addr_sh_d;
      data_sh_q     <= data_sh_d;
      tx_q          <= tx_d;
      miso_q        <= miso_d;
      reg_addr_q    <= reg_addr_d;
      reg_wr_en_q   <= reg_wr_en_d;
      reg_wr_data_q <= reg_wr_data_d;
      reg_rd_en_q   <= reg_rd_en_d;
      rd_load_q     <= rd_load_d;
      frame_err_q   <= frame_err_d;
      ovl_q         <= ovl_d;
    end
  end

  assign miso_oe     = (state_q == S_DATA) && !is_write_q;
  assign miso        = miso_q & miso_oe;
  assign busy        = (state_q != S_IDLE);
  assign reg_addr    = reg_addr_q;
  assign reg_wr_en   = reg_wr_en_q;
  assign reg_wr_data = reg_wr_data_q;
  assign reg_rd_en   = reg_rd_en_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_spi_sub.sv
// Bench for spi_sub: a task-level SPI main drives frames, a register-bank model
// predicts backend accesses, and a monitor pops expectations as strobes appear.
module tb_spi_sub;

  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk, cs, mosi;
  logic       miso, miso_oe;
  logic [5:0] reg_addr;
  logic       reg_wr_en, reg_rd_en;
  logic [7:0] reg_wr_data;
  logic [7:0] rd_data;
  logic       busy, frame_err;

  logic [7:0] be_mem [64];
  logic       pl_en;
  logic [5:0] pl_addr;
  logic [7:0] pl_val;

  logic [7:0]  model_mem [64];
  logic [13:0] wr_q[$];
  logic [5:0]  rd_q[$];
  int          err_pending;
  int          total;
  int          bad;

  spi_sub #(.ADDR_WIDTH(6), .DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .reg_addr(reg_addr),
    .reg_wr_en(reg_wr_en), .reg_wr_data(reg_wr_data),
    .reg_rd_en(reg_rd_en), .reg_rd_data(rd_data),
    .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Backend register bank: read data one clk after the request.
  always @(posedge clk) begin
    if (pl_en) be_mem[pl_addr] <= pl_val;
    if (reg_wr_en) be_mem[reg_addr] <= reg_wr_data;
    if (reg_rd_en) rd_data <= be_mem[reg_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm);
    total++;
    bad++;
    $display("FAIL %s: actual=strobe required=none (t=%0t)", nm, $time);
  endtask

  // Monitor: compares each backend strobe with the oldest expectation.
  initial begin
    logic [13:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (reg_wr_en) begin
          if (wr_q.size() == 0) unexpected("wr_unexpected");
          else begin
            e = wr_q.pop_front();
            chk("wr_addr", 32'(reg_addr), 32'(e[13:8]));
            chk("wr_data", 32'(reg_wr_data), 32'(e[7:0]));
          end
        end
        if (reg_rd_en) begin
          if (rd_q.size() == 0) unexpected("rd_unexpected");
          else chk("rd_addr", 32'(reg_addr), 32'(rd_q.pop_front()));
        end
        if (frame_err) begin
          if (err_pending == 0) unexpected("err_unexpected");
          else err_pending--;
        end
        if (!miso_oe && miso) chk("miso_idle", 32'(miso), 32'(0));
      end
    end
  end

  task automatic preload(input logic [5:0] a, input logic [7:0] v);
    pl_en = 1'b1; pl_addr = a; pl_val = v;
    model_mem[a] = v;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // nrises < 15 aborts the frame, > 15 makes it overlong.
  task automatic spi_frame(input logic rw, input logic [5:0] addr, input logic [7:0] data,
                           input int nrises, input bit cs_with_last, input int gap);
    logic [14:0] fr;
    logic [7:0]  got;
    logic [7:0]  exp_byte;
    bit          abort;
    fr = {rw, addr, data};
    got = '0;
    exp_byte = model_mem[addr];
    abort = (nrises < 15);
    if (!abort) begin
      if (rw) begin
        wr_q.push_back({addr, data});
        model_mem[addr] = data;
      end else rd_q.push_back(addr);
    end else if (!rw && nrises >= 7) rd_q.push_back(addr);
    if (nrises != 15) err_pending++;

    cs = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nrises; i++) begin
      sclk = 1'b0;
      mosi = (i < 15) ? fr[14-i] : 1'($urandom);
      repeat (HALF) @(negedge clk);
      chk("miso_oe", 32'(miso_oe), 32'(!rw && i >= 7 && i < 15));
      if (!rw && i >= 7 && i < 15) got[14-i] = miso;
      if (i >= 15) chk("miso_extra", 32'(miso), 32'(0));
      if (i == 0) chk("busy_frame", 32'(busy), 32'(1));
      if (cs_with_last && i == nrises - 1) cs = 1'b1;
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    cs = 1'b1;
    if (!rw && !abort) chk("rd_byte", 32'(got), 32'(exp_byte));
    if (gap > 0) begin
      repeat (gap) @(negedge clk);
    end else begin
      repeat (10) @(negedge clk);
      chk("busy_after", 32'(busy), 32'(0));
      chk("miso_oe_after", 32'(miso_oe), 32'(0));
      chk("wr_missing", 32'(wr_q.size()), 32'(0));
      chk("rd_missing", 32'(rd_q.size()), 32'(0));
      chk("err_missing", 32'(err_pending), 32'(0));
    end
  endtask

  initial begin
    total = 0; bad = 0; err_pending = 0;
    rst = 1'b1; sclk = 1'b1; cs = 1'b1; mosi = 1'b0; pl_en = 1'b0;
    pl_addr = '0; pl_val = '0;
    for (int a = 0; a < 64; a++) preload(6'(a), 8'($urandom));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_miso", 32'({miso, miso_oe}), 32'(0));
    chk("rst_strobes", 32'({reg_wr_en, reg_rd_en, frame_err}), 32'(0));
    chk("rst_addr", 32'(reg_addr), 32'(0));
    chk("rst_wdata", 32'(reg_wr_data), 32'(0));
    rst = 1'b0;
    repeat (4) @(negedge clk);

    spi_frame(1'b1, 6'h15, 8'hA5, 15, 1'b0, 0);
    preload(6'h2A, 8'h3C);
    spi_frame(1'b0, 6'h2A, 8'h00, 15, 1'b0, 0);
    spi_frame(1'b1, 6'h01, 8'h77, 10, 1'b0, 0);
    spi_frame(1'b1, 6'h02, 8'h11, 15, 1'b0, 0);
    spi_frame(1'b1, 6'h3F, 8'hFF, 18, 1'b0, 0);

    // Reset in the address phase of a write.
    cs = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      sclk = 1'b0; mosi = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_out", 32'({miso, miso_oe, reg_wr_en, reg_rd_en, frame_err}), 32'(0));
    chk("mid_rst_regs", 32'({reg_addr, reg_wr_data}), 32'(0));
    cs = 1'b1; sclk = 1'b1; mosi = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    preload(6'h00, 8'h81);
    spi_frame(1'b0, 6'h00, 8'h00, 15, 1'b0, 0);

    spi_frame(1'b1, 6'h05, 8'h11, 15, 1'b0, 1);
    spi_frame(1'b1, 6'h06, 8'h22, 15, 1'b0, 0);
    spi_frame(1'b1, 6'h09, 8'h5A, 15, 1'b1, 0);
    spi_frame(1'b0, 6'h09, 8'h00, 15, 1'b0, 0);

    for (int n = 0; n < 40; n++) begin
      int mode;
      int nr;
      mode = int'($urandom_range(0, 5));
      nr = (mode == 0) ? int'($urandom_range(0, 14)) :
           (mode == 1) ? 15 + int'($urandom_range(1, 3)) : 15;
      spi_frame(1'($urandom), 6'($urandom), 8'($urandom), nr, 1'b0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
